sqwave_meter: RTL and testbench

//   Measures the high time, low time and period, in clk cycles, of a square wave

---
 rtl/sqwave_meter_if.sv | 23 ++
 rtl/sqwave_meter.sv | 120 ++++++++++++
 tb/tb_sqwave_meter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sqwave_meter_if.sv
// Result/handshake bundle between sqwave_meter (master) and its consumer (slave).
// The master publishes one measurement set per period; the slave acknowledges it.
interface sqwave_meter_if #(
    parameter int CNT_W = 8
);
    logic             meas_ack;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic [CNT_W:0]   period;
    logic             meas_ovf;
    logic             meas_valid;
    logic             meas_lost;

    modport master (
        input  meas_ack,
        output high_cnt, low_cnt, period, meas_ovf, meas_valid, meas_lost
    );

    modport slave (
        output meas_ack,
        input  high_cnt, low_cnt, period, meas_ovf, meas_valid, meas_lost
    );
endinterface

// File: rtl/sqwave_meter.sv
// Square-wave meter: measures high time, low time and period of sig_in in clk
// cycles and hands one result set per complete rise-to-rise span to a consumer.
module sqwave_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sig_in,
    sqwave_meter_if.master m
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;
    logic                   s_prev;
    logic                   rise;
    logic                   fall;

    state_t           state;
    logic [CNT_W-1:0] hi_c;
    logic [CNT_W-1:0] lo_c;
    logic             ovf;
    logic             complete;
    logic             ack_take;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev;
    assign fall   = ~s_sync & s_prev;

    // A period closes on the rise that follows a low phase, but only while enabled.
    assign complete = en && (state == LOW) && rise;
    assign ack_take = m.meas_ack && m.meas_valid;

    // NOTE: every register below is assigned with <= so all flops update from
    // the same pre-edge values; blocking = here would chain the sync stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_prev <= s_sync;
        end
    end

    // NOTE: the result registers are plain flops, not a memory, so they take
    // the reset too; a consumer must never see stale fields after rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hi_c         <= '0;
            lo_c         <= '0;
            ovf          <= 1'b0;
            m.high_cnt   <= '0;
            m.low_cnt    <= '0;
            m.period     <= '0;
            m.meas_ovf   <= 1'b0;
            m.meas_valid <= 1'b0;
            m.meas_lost  <= 1'b0;
        end else begin
            if (!en) begin
                state <= IDLE;
                hi_c  <= '0;
                lo_c  <= '0;
                ovf   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        hi_c <= '0;
                        lo_c <= '0;
                        ovf  <= 1'b0;
                        if (rise) begin
                            state <= HIGH;
                            hi_c  <= CNT_ONE;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state <= LOW;
                            lo_c  <= CNT_ONE;
                        end else if (s_sync) begin
                            if (hi_c == CNT_MAX) ovf <= 1'b1;
                            else                 hi_c <= hi_c + CNT_ONE;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state <= HIGH;
                            hi_c  <= CNT_ONE;
                            lo_c  <= '0;
                            ovf   <= 1'b0;
                        end else if (!s_sync) begin
                            if (lo_c == CNT_MAX) ovf <= 1'b1;
                            else                 lo_c <= lo_c + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            // An overwrite is a completion landing on an unacked result.
            if (complete) begin
                m.high_cnt   <= hi_c;
                m.low_cnt    <= lo_c;
                m.period     <= {1'b0, hi_c} + {1'b0, lo_c};
                m.meas_ovf   <= ovf;
                m.meas_valid <= 1'b1;
                if (m.meas_valid && !m.meas_ack) m.meas_lost <= 1'b1;
            end else if (ack_take) begin
                m.meas_valid <= 1'b0;
                m.meas_lost  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sqwave_meter.sv
// Self-checking bench for sqwave_meter: two instances (CNT_W 8 and 4) share the
// stimulus and are compared every cycle against a run-length reference model.
module tb_sqwave_meter;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic sig_in = 1'b0;
    logic ack = 1'b0;

    int checks = 0;
    int failures = 0;

    sqwave_meter_if #(.CNT_W(8)) if8 ();
    sqwave_meter_if #(.CNT_W(4)) if4 ();

    assign if8.meas_ack = ack;
    assign if4.meas_ack = ack;

    sqwave_meter #(.CNT_W(8), .SYNC_STAGES(S)) dut8 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .m(if8)
    );
    sqwave_meter #(.CNT_W(4), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .m(if4)
    );

    always #5 clk = ~clk;

    // Reference model: sig_in delayed by the synchronizer, measured as run lengths
    // between rising edges; saturation is applied only when a result is published.
    int   hmax [2] = '{255, 15};
    logic h [0:S];
    bit   trk [2];
    bit   ph_high [2];
    int   hi_len [2];
    int   lo_len [2];
    int   e_high [2];
    int   e_low [2];
    int   e_per [2];
    bit   e_ovf [2];
    bit   e_valid [2];
    bit   e_lost [2];

    initial begin
        for (int k = 0; k <= S; k++) h[k] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            trk[i] = 0; ph_high[i] = 0; hi_len[i] = 0; lo_len[i] = 0;
            e_high[i] = 0; e_low[i] = 0; e_per[i] = 0;
            e_ovf[i] = 0; e_valid[i] = 0; e_lost[i] = 0;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_update();
        logic cur, prv;
        bit   done;
        cur = h[S-1];
        prv = h[S];
        if (rst) begin
            for (int k = 0; k <= S; k++) h[k] = 1'b0;
            for (int i = 0; i < 2; i++) begin
                trk[i] = 0; ph_high[i] = 0; hi_len[i] = 0; lo_len[i] = 0;
                e_high[i] = 0; e_low[i] = 0; e_per[i] = 0;
                e_ovf[i] = 0; e_valid[i] = 0; e_lost[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            done = 0;
            if (!en) begin
                trk[i] = 0;
            end else if (!trk[i]) begin
                if (cur && !prv) begin
                    trk[i] = 1; ph_high[i] = 1; hi_len[i] = 1; lo_len[i] = 0;
                end
            end else if (ph_high[i]) begin
                if (cur) hi_len[i]++;
                else begin ph_high[i] = 0; lo_len[i] = 1; end
            end else begin
                if (!cur) lo_len[i]++;
                else done = 1;
            end
            if (done) begin
                e_high[i] = sat(hi_len[i], hmax[i]);
                e_low[i]  = sat(lo_len[i], hmax[i]);
                e_per[i]  = e_high[i] + e_low[i];
                e_ovf[i]  = (hi_len[i] > hmax[i]) || (lo_len[i] > hmax[i]);
                if (e_valid[i] && !ack) e_lost[i] = 1;
                e_valid[i] = 1;
                ph_high[i] = 1; hi_len[i] = 1; lo_len[i] = 0;
            end else if (ack && e_valid[i]) begin
                e_valid[i] = 0;
                e_lost[i]  = 0;
            end
        end
        for (int k = S; k > 0; k--) h[k] = h[k-1];
        h[0] = sig_in;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic compare_all();
        check("d8.high_cnt",   32'(if8.high_cnt),   32'(e_high[0]));
        check("d8.low_cnt",    32'(if8.low_cnt),    32'(e_low[0]));
        check("d8.period",     32'(if8.period),     32'(e_per[0]));
        check("d8.meas_ovf",   32'(if8.meas_ovf),   32'(e_ovf[0]));
        check("d8.meas_valid", 32'(if8.meas_valid), 32'(e_valid[0]));
        check("d8.meas_lost",  32'(if8.meas_lost),  32'(e_lost[0]));
        check("d4.high_cnt",   32'(if4.high_cnt),   32'(e_high[1]));
        check("d4.low_cnt",    32'(if4.low_cnt),    32'(e_low[1]));
        check("d4.period",     32'(if4.period),     32'(e_per[1]));
        check("d4.meas_ovf",   32'(if4.meas_ovf),   32'(e_ovf[1]));
        check("d4.meas_valid", 32'(if4.meas_valid), 32'(e_valid[1]));
        check("d4.meas_lost",  32'(if4.meas_lost),  32'(e_lost[1]));
    endtask

    // Inputs change on the falling edge; outputs are compared on the next falling edge.
    task automatic step(input logic s, input logic e, input logic a, input logic r);
        sig_in = s; en = e; ack = a; rst = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    // ack mode: 0 never, 1 follow expected valid, 2 always, 3 random.
    task automatic hold(input logic s, input int n, input int mode);
        logic a;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       a = 1'b0;
                1:       a = e_valid[0];
                2:       a = 1'b1;
                default: a = 1'($urandom_range(0, 1));
            endcase
            step(s, 1'b1, a, 1'b0);
        end
    endtask

    task automatic run_wave(input int hi, input int lo, input int reps, input int mode);
        for (int k = 0; k < reps; k++) begin
            hold(1'b1, hi, mode);
            hold(1'b0, lo, mode);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   run;
        logic s, e, a, r;
        @(negedge clk);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst.valid", 32'(if8.meas_valid), 0);
        check("rst.high",  32'(if8.high_cnt), 0);
        check("rst.lost",  32'(if4.meas_lost), 0);

        run_wave(5, 3, 4, 1);
        check("w53.high", 32'(if8.high_cnt), 5);
        check("w53.low",  32'(if8.low_cnt), 3);
        check("w53.per",  32'(if8.period), 8);
        check("w53.ovf",  32'(if8.meas_ovf), 0);

        run_wave(1, 1, 6, 1);
        check("tog.high", 32'(if8.high_cnt), 1);
        check("tog.low",  32'(if8.low_cnt), 1);
        check("tog.per",  32'(if8.period), 2);

        hold(1'b1, 20, 1); hold(1'b0, 2, 1); hold(1'b1, S + 1, 1);
        check("sat.d4_high", 32'(if4.high_cnt), 15);
        check("sat.d4_low",  32'(if4.low_cnt), 2);
        check("sat.d4_per",  32'(if4.period), 17);
        check("sat.d4_ovf",  32'(if4.meas_ovf), 1);
        check("sat.d8_per",  32'(if8.period), 22);
        hold(1'b1, 5 - (S + 1), 1); hold(1'b0, 3, 1); hold(1'b1, S + 1, 1);
        check("unsat.d4_per", 32'(if4.period), 8);
        check("unsat.d4_ovf", 32'(if4.meas_ovf), 0);

        hold(1'b1, 1, 1);
        hold(1'b0, 4, 0); hold(1'b1, 4, 0);
        hold(1'b0, 4, 0); hold(1'b1, 6, 0);
        hold(1'b0, 2, 0); hold(1'b1, S + 1, 0);
        check("lost.high",  32'(if8.high_cnt), 6);
        check("lost.low",   32'(if8.low_cnt), 2);
        check("lost.valid", 32'(if8.meas_valid), 1);
        check("lost.lost",  32'(if8.meas_lost), 1);
        hold(1'b1, 1, 2);
        check("ack.valid", 32'(if8.meas_valid), 0);
        check("ack.lost",  32'(if8.meas_lost), 0);

        hold(1'b0, 3, 0); hold(1'b1, S + 1, 0);
        check("pre.high", 32'(if8.high_cnt), 4);
        hold(1'b1, 2, 0); hold(1'b0, 3, 0); hold(1'b1, S, 0); hold(1'b1, 1, 2);
        check("coack.valid", 32'(if8.meas_valid), 1);
        check("coack.lost",  32'(if8.meas_lost), 0);
        check("coack.high",  32'(if8.high_cnt), 5);
        check("coack.low",   32'(if8.low_cnt), 3);

        hold(1'b1, 2, 1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("midrst.high",  32'(if8.high_cnt), 0);
        check("midrst.per",   32'(if4.period), 0);
        check("midrst.valid", 32'(if8.meas_valid), 0);
        hold(1'b1, 5, 1); hold(1'b0, 3, 1);
        check("first.valid", 32'(if8.meas_valid), 0);
        hold(1'b1, S + 1, 0);
        check("second.valid", 32'(if8.meas_valid), 1);
        check("second.per",   32'(if8.period), 8);

        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("dis.valid", 32'(if8.meas_valid), 1);
        check("dis.high",  32'(if8.high_cnt), 5);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("dis.ack", 32'(if8.meas_valid), 0);
        run_wave(5, 3, 3, 1);

        run = 0;
        s = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (run == 0) begin
                s = ~s;
                run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                  : int'($urandom_range(1, 24));
            end
            run--;
            e = ($urandom_range(0, 49) != 0);
            a = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(s, e, a, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
